// File: rtl/cmp_serial_signed.sv
// Bit-serial signed comparator: walks operands LSB to MSB, one bit per clock,
// and reports lt/eq/gt with a single-cycle done pulse.
module cmp_serial_signed #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [CNT_W-1:0] cnt;
   logic             f_lt;
   logic             f_gt;
   logic             f_lt_next;
   logic             f_gt_next;
   logic             last_bit;
   logic             accept;

   assign last_bit = (cnt == LAST_BIT);
   assign accept   = (state == IDLE) && start;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and running-flag update; the sign bit uses the inverted rule
   always_comb begin
      state_next = state;
      f_lt_next  = f_lt;
      f_gt_next  = f_gt;
      case (state)
         IDLE: begin
            if (start) state_next = SHIFT;
         end
         SHIFT: begin
            if (xs[0] != ys[0]) begin
               if (last_bit) begin
                  f_lt_next = xs[0];
                  f_gt_next = ys[0];
               end else begin
                  f_lt_next = ys[0];
                  f_gt_next = xs[0];
               end
            end
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand shift registers, bit counter and running flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs   <= '0;
         ys   <= '0;
         cnt  <= '0;
         f_lt <= 1'b0;
         f_gt <= 1'b0;
      end else if (accept) begin
         xs   <= x;
         ys   <= y;
         cnt  <= '0;
         f_lt <= 1'b0;
         f_gt <= 1'b0;
      end else if (state == SHIFT) begin
         xs   <= {1'b0, xs[WIDTH-1:1]};
         ys   <= {1'b0, ys[WIDTH-1:1]};
         f_lt <= f_lt_next;
         f_gt <= f_gt_next;
         if (!last_bit) cnt <= cnt + CNT_W'(1);
      end
   end

   // Registered status and results; results only move on DONE entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         lt   <= 1'b0;
         eq   <= 1'b0;
         gt   <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         done <= (state_next == DONE);
         if ((state == SHIFT) && last_bit) begin
            lt <= f_lt_next;
            gt <= f_gt_next;
            eq <= ~(f_lt_next | f_gt_next);
         end
      end
   end

endmodule
